// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding,
// default geometry and the tick-counter width helper.
package uart_tx_buffered_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;

  localparam int DEF_NB_DATA = 8;
  localparam int DEF_S_TICK  = 16;
  localparam int DEF_SB_TICK = 16;
  localparam int DEF_FIFO_W  = 4;
  localparam int DEPTH       = 2 ** DEF_FIFO_W;

  // Width needed to count 0..max(s,sb)-1, never narrower than one bit.
  function automatic int tick_w(input int s, input int sb);
    int m;
    m = (s > sb) ? s : sb;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  localparam int TICK_W = tick_w(DEF_S_TICK, DEF_SB_TICK);

endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous FIFO feeding the serializer. Occupancy is tracked explicitly so
// full/empty/level all come from one registered count.
module tx_fifo #(
  parameter int NB_DATA = 8,
  parameter int FIFO_W  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr,
  input  logic               rd,
  input  logic [NB_DATA-1:0] w_data,
  output logic [NB_DATA-1:0] r_data,
  output logic               full,
  output logic               empty,
  output logic [FIFO_W:0]    level
);

  localparam int NUM_WORDS = 2 ** FIFO_W;

  logic [NB_DATA-1:0] mem [NUM_WORDS];
  logic [FIFO_W-1:0]  wr_ptr;
  logic [FIFO_W-1:0]  rd_ptr;
  logic [FIFO_W:0]    count;
  logic               wr_ok;
  logic               rd_ok;

  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty;

  // NOTE: the storage array has no reset; only pointers and count decide
  // which entries are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= w_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // count never exceeds NUM_WORDS, so its top bit alone marks full.
  assign full   = count[FIFO_W];
  assign empty  = (count == '0);
  assign level  = count;
  assign r_data = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: producer writes into tx_fifo, a 16x
// oversampled serializer drains it and sends frames back-to-back.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int S_TICK  = DEF_S_TICK,
  parameter int SB_TICK = DEF_SB_TICK,
  parameter int FIFO_W  = DEF_FIFO_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_tick,
  input  logic               wr,
  input  logic [NB_DATA-1:0] w_data,
  output logic               full,
  output logic               empty,
  output logic [FIFO_W:0]    level,
  output logic               overflow,
  output logic               tx_busy,
  output logic               tx_done_tick,
  output logic               tx_serial
);

  localparam int T_W  = tick_w(S_TICK, SB_TICK);
  localparam int N_W  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [T_W-1:0] S_LAST  = T_W'(S_TICK - 1);
  localparam logic [T_W-1:0] SB_LAST = T_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST  = N_W'(NB_DATA - 1);

  state_t             state, state_next;
  logic [T_W-1:0]     t, t_next;
  logic [N_W-1:0]     n, n_next;
  logic [NB_DATA-1:0] b, b_next;
  logic               tx_reg, tx_next;
  logic               overflow_reg;
  logic               fifo_rd;
  logic [NB_DATA-1:0] fifo_data;

  tx_fifo #(
    .NB_DATA(NB_DATA),
    .FIFO_W (FIFO_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .rd    (fifo_rd),
    .w_data(w_data),
    .r_data(fifo_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // NOTE: non-blocking assignments here so every register updates from
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      t            <= '0;
      n            <= '0;
      b            <= '0;
      tx_reg       <= 1'b1;
      overflow_reg <= 1'b0;
    end else begin
      state        <= state_next;
      t            <= t_next;
      n            <= n_next;
      b            <= b_next;
      tx_reg       <= tx_next;
      overflow_reg <= wr & full;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    t_next       = t;
    n_next       = n;
    b_next       = b;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          fifo_rd    = 1'b1;
          b_next     = fifo_data;
          t_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (t == S_LAST) begin
            t_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            t_next = t + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (t == S_LAST) begin
            t_next = '0;
            b_next = b >> 1;
            if (n == N_LAST) state_next = STOP;
            else             n_next     = n + 1'b1;
          end else begin
            t_next = t + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (t == SB_LAST) begin
            tx_done_tick = 1'b1;
            state_next   = IDLE;
          end else begin
            t_next = t + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Line level follows the state being entered so tx_serial stays registered
    // yet changes on the same edge as the state.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign tx_serial = tx_reg;
  assign overflow  = overflow_reg;
  assign tx_busy   = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed self-checking bench for uart_tx_buffered: reset, single frame,
// back-to-back burst, FIFO full/overflow, mid-frame reset, write at done.
module tb_uart_tx_buffered;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       wr;
  logic [7:0] w_data;
  logic       full, empty, overflow, tx_busy, tx_done_tick, tx_serial;
  logic [4:0] level;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  done_cnt = 0;
  bit  tick_en  = 1'b0;
  int  tick_div = 0;

  localparam int FRAME_TICKS = (1 + 8) * 16 + 16;

  uart_tx_buffered dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .wr          (wr),
    .w_data      (w_data),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .tx_busy     (tx_busy),
    .tx_done_tick(tx_done_tick),
    .tx_serial   (tx_serial)
  );

  initial forever #5 clk = ~clk;

  // s_tick: one clk wide every 4 clk, changed just after posedge.
  initial begin
    s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_div = (tick_div + 1) % 4;
      s_tick   = tick_en && (tick_div == 0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (tx_done_tick === 1'b1) done_cnt++;
  end

  task automatic write_byte(input logic [7:0] d);
    wr = 1'b1;
    w_data = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Receives one frame by counting s_tick pulses while busy and sampling the
  // line mid-bit (ticks 8, 24, ... 152). gap = negedges waited for start.
  task automatic rx_frame(input logic [7:0] exp, input string name, output int gap);
    int         cyc;
    int         ticks;
    bit         done;
    logic [9:0] bits;
    cyc = 0;
    while (tx_serial !== 1'b0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    gap = cyc;
    n_checks++;
    if (tx_serial !== 1'b0) begin
      $display("FAIL %s_start: line=%b after %0d clk, required start bit 0", name, tx_serial, cyc);
      return;
    end else n_pass++;
    ticks = 0;
    done  = 1'b0;
    bits  = '0;
    while (!done && cyc < 4000) begin
      if (s_tick === 1'b1 && tx_busy === 1'b1) begin
        ticks++;
        if (ticks % 16 == 8 && ticks / 16 < 10) bits[ticks/16] = tx_serial;
      end
      if (tx_done_tick === 1'b1) done = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    n_checks++;
    if (!done) $display("FAIL %s_done: no tx_done_tick after %0d clk, required one", name, cyc);
    else n_pass++;
    n_checks++;
    if (bits !== {1'b1, exp, 1'b0})
      $display("FAIL %s_bits: got stop/data/start %b, required %b", name, bits, {1'b1, exp, 1'b0});
    else n_pass++;
    n_checks++;
    if (ticks != FRAME_TICKS)
      $display("FAIL %s_ticks: frame took %0d ticks, required %0d", name, ticks, FRAME_TICKS);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wr = 1'b0;
    w_data = 8'h00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      wr = ~wr;
      w_data = 8'(8'h30 + i);
      @(negedge clk);
    end
    wr = 1'b0;
    n_checks++;
    if ({tx_serial, empty, full, level, overflow, tx_busy, tx_done_tick} !== {1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_state: serial/empty/full/level/ovf/busy/done=%b%b%b_%0d_%b%b%b, required 110_0_000",
               tx_serial, empty, full, level, overflow, tx_busy, tx_done_tick);
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tx_serial, empty, level, tx_busy} !== {1'b1, 1'b1, 5'd0, 1'b0})
      $display("FAIL reset_release: serial/empty/level/busy=%b%b_%0d_%b, required 11_0_0",
               tx_serial, empty, level, tx_busy);
    else n_pass++;
  endtask

  task automatic test_single();
    int gap;
    int d0;
    tick_en = 1'b1;
    d0 = done_cnt;
    write_byte(8'hA5);
    rx_frame(8'hA5, "single_a5", gap);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({level, empty, tx_busy, tx_serial} !== {5'd0, 1'b1, 1'b0, 1'b1})
      $display("FAIL single_after: level/empty/busy/serial=%0d_%b%b%b, required 0_101", level, empty, tx_busy, tx_serial);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL single_done_count: got %0d pulses, required 1", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int         gap;
    int         d0;
    logic [4:0] l1, l2, l3;
    d0 = done_cnt;
    wr = 1'b1;
    w_data = 8'h00;
    @(negedge clk);
    l1 = level;
    w_data = 8'hFF;
    @(negedge clk);
    l2 = level;
    w_data = 8'h55;
    @(negedge clk);
    l3 = level;
    wr = 1'b0;
    n_checks++;
    if ({l1, l2, l3} !== {5'd1, 5'd1, 5'd2})
      $display("FAIL b2b_level: got %0d,%0d,%0d, required 1,1,2", l1, l2, l3);
    else n_pass++;
    rx_frame(8'h00, "b2b_00", gap);
    rx_frame(8'hFF, "b2b_ff", gap);
    n_checks++;
    if (gap != 2) $display("FAIL b2b_gap_ff: start %0d clk after done, required 2", gap);
    else n_pass++;
    rx_frame(8'h55, "b2b_55", gap);
    n_checks++;
    if (gap != 2) $display("FAIL b2b_gap_55: start %0d clk after done, required 2", gap);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 != 3) $display("FAIL b2b_done_count: got %0d pulses, required 3", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_full_overflow();
    int gap;
    int d0;
    int bad_gaps;
    tick_en = 1'b0;
    repeat (3) @(negedge clk);
    d0 = done_cnt;
    for (int i = 1; i <= 17; i++) begin
      wr = 1'b1;
      w_data = 8'(i);
      @(negedge clk);
    end
    wr = 1'b0;
    n_checks++;
    if ({level, full, empty, overflow, tx_busy, tx_serial} !== {5'd16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0})
      $display("FAIL full_state: level/full/empty/ovf/busy/serial=%0d_%b%b%b%b%b, required 16_10010",
               level, full, empty, overflow, tx_busy, tx_serial);
    else n_pass++;
    write_byte(8'h12);
    n_checks++;
    if ({overflow, level} !== {1'b1, 5'd16})
      $display("FAIL overflow_pulse: overflow=%b level=%0d, required 1 and 16", overflow, level);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({overflow, level} !== {1'b0, 5'd16})
      $display("FAIL overflow_clear: overflow=%b level=%0d, required 0 and 16", overflow, level);
    else n_pass++;
    tick_en = 1'b1;
    bad_gaps = 0;
    for (int i = 1; i <= 17; i++) begin
      rx_frame(8'(i), $sformatf("full_frame_%0d", i), gap);
      if (i > 1 && gap != 2) bad_gaps++;
    end
    n_checks++;
    if (bad_gaps != 0) $display("FAIL full_gaps: %0d frames with idle gap != 1 clk, required 0", bad_gaps);
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done_cnt - d0, 32'(empty)} !== {32'd17, 32'd1})
      $display("FAIL full_drain: %0d done pulses empty=%b, required 17 and 1", done_cnt - d0, empty);
    else n_pass++;
  endtask

  task automatic test_mid_frame_reset();
    int gap;
    int ticks;
    int cyc;
    int d0;
    d0 = done_cnt;
    write_byte(8'h3C);
    cyc = 0;
    ticks = 0;
    // Bit n=3 spans ticks 64..79 after the start edge; stop at tick 72.
    while (ticks < 72 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (s_tick === 1'b1 && tx_busy === 1'b1) ticks++;
    end
    n_checks++;
    if ({tx_busy, tx_serial} !== {1'b1, 1'b1})
      $display("FAIL midrst_pre: busy=%b serial=%b at tick %0d, required 1 and 1 (bit3 of 3C)", tx_busy, tx_serial, ticks);
    else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({tx_serial, empty, tx_busy, tx_done_tick, level} !== {1'b1, 1'b1, 1'b0, 1'b0, 5'd0})
      $display("FAIL midrst_async: serial/empty/busy/done=%b%b%b%b level=%0d, required 1100 and 0",
               tx_serial, empty, tx_busy, tx_done_tick, level);
    else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (done_cnt != d0) $display("FAIL midrst_no_done: got %0d pulses, required 0", done_cnt - d0);
    else n_pass++;
    write_byte(8'h7E);
    rx_frame(8'h7E, "midrst_7e", gap);
  endtask

  task automatic test_write_at_done();
    int gap;
    int cyc;
    write_byte(8'h96);
    cyc = 0;
    while (tx_done_tick !== 1'b1 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (tx_done_tick !== 1'b1) $display("FAIL wad_done: no tx_done_tick within %0d clk, required one", cyc);
    else n_pass++;
    // Write presented in the done cycle; captured on the edge that ends STOP.
    wr = 1'b1;
    w_data = 8'hC3;
    @(negedge clk);
    wr = 1'b0;
    n_checks++;
    if ({tx_serial, tx_busy, level} !== {1'b1, 1'b0, 5'd1})
      $display("FAIL wad_edge1: serial/busy=%b%b level=%0d, required 10 and 1", tx_serial, tx_busy, level);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({tx_serial, tx_busy, level} !== {1'b0, 1'b1, 5'd0})
      $display("FAIL wad_edge2: serial/busy=%b%b level=%0d, required 01 and 0", tx_serial, tx_busy, level);
    else n_pass++;
    rx_frame(8'hC3, "wad_c3", gap);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_overflow();
    test_mid_frame_reset();
    test_write_at_done();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
